// File: rtl/fifo_column_reader.sv
// Drain-side reader for the multi-column word FIFO: pops one COLUMN-wide word
// and serialises it element 0 first onto a B-bit valid/ready stream.
module fifo_column_reader #(
  parameter int B      = 8,
  parameter int COLUMN = 3,
  localparam int CW    = (COLUMN > 1) ? $clog2(COLUMN) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fifo_empty,
  output logic          fifo_rd,
  input  logic [B-1:0]  fifo_r_data [COLUMN-1:0],
  input  logic          flush,
  output logic [B-1:0]  m_data,
  output logic [CW-1:0] m_col,
  output logic          m_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(COLUMN - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [B-1:0]  hold_q [COLUMN-1:0];
  logic [B-1:0]  hold_d [COLUMN-1:0];
  logic          accept;
  logic          at_last;
  logic          pop;

  assign m_valid = (state_q == SEND);
  assign busy    = m_valid;
  assign m_col   = col_q;
  assign at_last = (col_q == COL_LAST);
  // Gated by m_valid so the reset/idle value is 0 even when COLUMN is 1.
  assign m_last  = m_valid & at_last;
  assign accept  = m_valid & m_ready;
  assign fifo_rd = pop;

  generate
    if (COLUMN == 1) begin : g_single
      assign m_data = hold_q[0];
    end else begin : g_multi
      assign m_data = hold_q[col_q];
    end
  endgenerate

  // Pop decision and next-state: flush wins, then reload, then column advance.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    hold_d  = hold_q;
    pop     = ~reset & ~fifo_empty & ~flush &
              ((state_q == IDLE) | (accept & at_last));
    if (flush) begin
      state_d = IDLE;
    end else if (pop) begin
      hold_d  = fifo_r_data;
      col_d   = '0;
      state_d = SEND;
    end else if (accept & ~at_last) begin
      col_d   = col_q + CW'(1);
    end else if (accept) begin
      state_d = IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // State, column index and holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      for (int i = 0; i < COLUMN; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_fifo_column_reader.sv
// Directed bench for fifo_column_reader: a COLUMN=3 instance and a COLUMN=1
// instance, each fed from a small queue acting as a show-ahead FIFO.
module tb_fifo_column_reader;

  logic       clk = 1'b0;
  logic       reset;

  logic       fifo_empty, fifo_rd, flush, m_last, m_valid, m_ready, busy;
  logic [7:0] fifo_r_data [2:0];
  logic [7:0] m_data;
  logic [1:0] m_col;

  logic       fifo_empty1, fifo_rd1, flush1, m_last1, m_valid1, m_ready1, busy1;
  logic [7:0] fifo_r_data1 [0:0];
  logic [7:0] m_data1;
  logic [0:0] m_col1;

  int n_checks = 0;
  int n_fail   = 0;
  int pops3    = 0;
  int pops1    = 0;

  logic [23:0] q3 [$];
  logic [7:0]  q1 [$];

  always #5 clk = ~clk;

  fifo_column_reader #(.B(8), .COLUMN(3)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_r_data(fifo_r_data), .flush(flush), .m_data(m_data), .m_col(m_col),
    .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
  );

  fifo_column_reader #(.B(8), .COLUMN(1)) dut1 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty1), .fifo_rd(fifo_rd1),
    .fifo_r_data(fifo_r_data1), .flush(flush1), .m_data(m_data1), .m_col(m_col1),
    .m_last(m_last1), .m_valid(m_valid1), .m_ready(m_ready1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    logic [23:0] w;
    w = '0;
    if (q3.size() > 0) w = q3[0];
    fifo_empty = (q3.size() == 0);
    for (int i = 0; i < 3; i++) fifo_r_data[i] = w[8*i +: 8];
    fifo_empty1     = (q1.size() == 0);
    fifo_r_data1[0] = (q1.size() > 0) ? q1[0] : 8'h00;
  endtask

  // Advance one clock; the queue pops when the DUT strobed fifo_rd that cycle.
  task automatic tick();
    logic r3, r1;
    r3 = fifo_rd;
    r1 = fifo_rd1;
    @(posedge clk);
    #1;
    if (r3 && q3.size() > 0) begin
      void'(q3.pop_front());
      pops3++;
    end
    if (r1 && q1.size() > 0) begin
      void'(q1.pop_front());
      pops1++;
    end
    drive_fifo();
    @(negedge clk);
  endtask

  task automatic beat(input string tag, input bit v, input logic [7:0] d,
                      input logic [1:0] c, input bit l, input bit rd);
    #1;
    chk({tag, ".valid"}, m_valid, v);
    chk({tag, ".busy"}, busy, v);
    chk({tag, ".rd"}, fifo_rd, rd);
    chk({tag, ".last"}, m_last, l);
    if (v) begin
      chk({tag, ".data"}, m_data, d);
      chk({tag, ".col"}, m_col, c);
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;  m_ready = 1'b0;
    flush1 = 1'b0; m_ready1 = 1'b0;
    drive_fifo();
    @(negedge clk);
    @(negedge clk);

    // Reset state, with a non-empty FIFO to show no pop happens under reset.
    q3.push_back(24'hABCDEF);
    q1.push_back(8'h55);
    drive_fifo();
    beat("rst", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    chk("rst.data", m_data, 8'h00);
    chk("rst.col", m_col, 2'd0);
    chk("rst1.rd", fifo_rd1, 1'b0);
    chk("rst1.valid", m_valid1, 1'b0);
    chk("rst1.last", m_last1, 1'b0);
    chk("rst1.data", m_data1, 8'h00);
    q3.delete();
    q1.delete();
    drive_fifo();
    reset = 1'b0;
    tick();

    // Single word.
    q3.push_back(24'h332211);
    drive_fifo();
    m_ready = 1'b1;
    beat("w1.pop", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    tick(); beat("w1.b0", 1'b1, 8'h11, 2'd0, 1'b0, 1'b0);
    tick(); beat("w1.b1", 1'b1, 8'h22, 2'd1, 1'b0, 1'b0);
    tick(); beat("w1.b2", 1'b1, 8'h33, 2'd2, 1'b1, 1'b0);
    tick(); beat("w1.idle", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    chk("w1.pops", pops3, 1);

    // Back-to-back words, second pop on the last beat of the first.
    q3.push_back(24'h030201);
    q3.push_back(24'h060504);
    drive_fifo();
    beat("bb.pop", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    tick(); beat("bb.b0", 1'b1, 8'h01, 2'd0, 1'b0, 1'b0);
    tick(); beat("bb.b1", 1'b1, 8'h02, 2'd1, 1'b0, 1'b0);
    tick(); beat("bb.b2", 1'b1, 8'h03, 2'd2, 1'b1, 1'b1);
    tick(); beat("bb.b3", 1'b1, 8'h04, 2'd0, 1'b0, 1'b0);
    tick(); beat("bb.b4", 1'b1, 8'h05, 2'd1, 1'b0, 1'b0);
    tick(); beat("bb.b5", 1'b1, 8'h06, 2'd2, 1'b1, 1'b0);
    tick(); beat("bb.idle", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    chk("bb.pops", pops3, 3);

    // Backpressure on element 1 with another word already waiting.
    q3.push_back(24'hC0B0A0);
    drive_fifo();
    beat("bp.pop", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    tick(); beat("bp.b0", 1'b1, 8'hA0, 2'd0, 1'b0, 1'b0);
    tick();
    q3.push_back(24'hD3D2D1);
    drive_fifo();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat("bp.hold", 1'b1, 8'hB0, 2'd1, 1'b0, 1'b0);
      tick();
    end
    m_ready = 1'b1;
    beat("bp.rel", 1'b1, 8'hB0, 2'd1, 1'b0, 1'b0);
    tick(); beat("bp.b2", 1'b1, 8'hC0, 2'd2, 1'b1, 1'b1);
    tick(); beat("bp.d0", 1'b1, 8'hD1, 2'd0, 1'b0, 1'b0);
    tick(); beat("bp.d1", 1'b1, 8'hD2, 2'd1, 1'b0, 1'b0);
    tick(); beat("bp.d2", 1'b1, 8'hD3, 2'd2, 1'b1, 1'b0);
    tick(); beat("bp.idle", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    chk("bp.pops", pops3, 5);

    // Empty FIFO with toggling ready.
    for (int i = 0; i < 20; i++) begin
      m_ready = (i % 2 == 1);
      #1;
      chk("empty.rd", fifo_rd, 1'b0);
      chk("empty.valid", m_valid, 1'b0);
      tick();
    end

    // Flush mid-word, then flush coincident with a last-beat accept.
    m_ready = 1'b1;
    q3.push_back(24'h302010);
    q3.push_back(24'h605040);
    q3.push_back(24'h908070);
    drive_fifo();
    beat("fl.pop", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    tick(); beat("fl.b0", 1'b1, 8'h10, 2'd0, 1'b0, 1'b0);
    tick();
    flush = 1'b1;
    beat("fl.b1", 1'b1, 8'h20, 2'd1, 1'b0, 1'b0);
    tick();
    flush = 1'b0;
    beat("fl.gone", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    tick(); beat("fl.n0", 1'b1, 8'h40, 2'd0, 1'b0, 1'b0);
    tick(); beat("fl.n1", 1'b1, 8'h50, 2'd1, 1'b0, 1'b0);
    tick();
    flush = 1'b1;
    beat("fl.lastfl", 1'b1, 8'h60, 2'd2, 1'b1, 1'b0);
    tick();
    flush = 1'b0;
    beat("fl.idle", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    tick(); beat("fl.c0", 1'b1, 8'h70, 2'd0, 1'b0, 1'b0);
    tick(); beat("fl.c1", 1'b1, 8'h80, 2'd1, 1'b0, 1'b0);
    chk("fl.pops", pops3, 8);

    // Asynchronous reset in the middle of a word.
    reset = 1'b1;
    beat("mrst", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    chk("mrst.data", m_data, 8'h00);
    chk("mrst.col", m_col, 2'd0);
    q3.delete();
    drive_fifo();
    tick();
    reset = 1'b0;
    tick();

    // COLUMN=1 instance: one pop per beat, every beat last.
    m_ready1 = 1'b1;
    q1.push_back(8'h7E);
    q1.push_back(8'h7F);
    drive_fifo();
    #1;
    chk("c1.pop", fifo_rd1, 1'b1);
    chk("c1.idle", m_valid1, 1'b0);
    tick(); #1;
    chk("c1.b0.valid", m_valid1, 1'b1);
    chk("c1.b0.data", m_data1, 8'h7E);
    chk("c1.b0.col", m_col1, 1'b0);
    chk("c1.b0.last", m_last1, 1'b1);
    chk("c1.b0.rd", fifo_rd1, 1'b1);
    tick(); #1;
    chk("c1.b1.valid", m_valid1, 1'b1);
    chk("c1.b1.data", m_data1, 8'h7F);
    chk("c1.b1.last", m_last1, 1'b1);
    chk("c1.b1.rd", fifo_rd1, 1'b0);
    tick(); #1;
    chk("c1.end.valid", m_valid1, 1'b0);
    chk("c1.end.busy", busy1, 1'b0);
    chk("c1.pops", pops1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_column_reader.md
# fifo_column_reader

Drain-side consumer for the multi-column word FIFO in the BWT datapath. It pops one COLUMN-wide word from the FIFO's read port whenever the FIFO is non-empty and it has room. It then serialises that word onto a B-bit valid/ready stream, one column element per beat, with element 0 first. It is the reader-end counterpart of the FIFO write path and feeds the downstream per-symbol stage.

## Interface

- B, 8, bits per column element (matches FIFO word element width)
- COLUMN, 3, elements per FIFO word; legal range 1..256
- CW, $clog2(COLUMN) clamped to minimum 1, derived; width of column index
- clk  input  1  clock, all state on rising edge
- reset  input  1  reset, asynchronous, active-high
- fifo_empty  input  1  FIFO empty flag
- fifo_rd  output  1  FIFO pop strobe; combinational
- fifo_r_data  input  B x [COLUMN-1:0] (unpacked array)  FIFO head word; valid while fifo_empty=0 (show-ahead)
- flush  input  1  synchronous abort of the word currently being sent
- m_data  output  B  current element
- m_col  output  CW  index of current element within its word
- m_last  output  1  high on element COLUMN-1
- m_valid  output  1  beat valid
- m_ready  input  1  downstream accepts beat
- busy  output  1  a word is held (m_valid=1)

## Operation

- Holding register: COLUMN x B word buffer, loaded only on a pop.
- States:
  - IDLE: m_valid=0.
  - SEND: m_valid=1, col = index of the element being presented.
- fifo_rd = ~fifo_empty & ~flush & (state==IDLE | (m_valid & m_ready & m_last)). Never asserted while fifo_empty=1.
- On fifo_rd:
  - Holding register <= fifo_r_data.
  - col <= 0.
  - State <= SEND.
- Accept (m_valid & m_ready), not last: col <= col+1, state stays SEND.
- Accept on last:
  - If fifo_rd is high the same cycle, load the next word (zero bubble).
  - Otherwise state <= IDLE.
- m_data = holding[col], m_col = col, m_last = (col==COLUMN-1). All are registered-state derived and do not depend combinationally on m_ready.
- While m_valid & ~m_ready: m_data, m_col and m_last hold stable, and no pop occurs.
- COLUMN=1: every beat has m_last=1; a pop can occur on every accepted beat.
- Column counter wraps only through reload; it never exceeds COLUMN-1.
- flush (synchronous, priority over everything except reset):
  - Next state IDLE, m_valid=0.
  - fifo_rd=0 in the flush cycle.
  - The remaining elements of the held word are discarded.
- busy = m_valid.

## Timing

- Reset values: state IDLE, m_valid 0, m_last 0, m_col 0, m_data 0 (holding register cleared), busy 0. fifo_rd is 0 during reset.
- Latency: fifo_empty falls in cycle N, so fifo_rd is high in cycle N and m_valid rises in N+1 with element 0.
- Throughput: one element per cycle with m_ready=1. COLUMN cycles per word; no gap between words if the FIFO is non-empty at the last beat.
- fifo_rd is a single-cycle pulse per word; at most one pop per COLUMN accepted beats.
- Simultaneous events:
  - Last-beat accept with fifo_empty=1 goes to IDLE. A word arriving the next cycle is popped that cycle and appears one cycle later (one bubble).
  - flush coincident with a last-beat accept: the beat counts as accepted, but no pop occurs; next state IDLE.
- Reset mid-word: outputs return to reset values immediately. The popped word is lost; the FIFO is reset by the same reset.

## Test plan

- Single word: FIFO holds {0x11,0x22,0x33} (col0..2), m_ready=1.
  - fifo_rd pulses exactly 1 cycle.
  - Beats 0x11/0, 0x22/1, 0x33/2 on 3 consecutive cycles starting 1 cycle after the pop.
  - m_last only on 0x33; then m_valid=0, busy=0.
- Back-to-back: two words {0x01,0x02,0x03}, {0x04,0x05,0x06} queued, m_ready=1.
  - 6 consecutive beats, no bubble.
  - Second fifo_rd coincides with the cycle the 0x03 beat is accepted.
- Backpressure: during word {0xA0,0xB0,0xC0}, m_ready=0 for 3 cycles while 0xB0 is presented.
  - m_data=0xB0, m_col=1 held stable.
  - No fifo_rd, even though the FIFO is non-empty.
  - Then 0xC0 follows.
- Empty FIFO: fifo_empty=1 for 20 cycles, m_ready toggling → fifo_rd=0 and m_valid=0 throughout.
- Flush: assert flush while m_col=1 of {0x10,0x20,0x30}.
  - m_valid=0 the next cycle; 0x30 is never emitted.
  - The next queued word {0x40,0x50,0x60} starts cleanly at m_col=0.
- Reset mid-word, then COLUMN=1 config:
  - Reset mid-word: all outputs 0 immediately.
  - COLUMN=1 build with words 0x7E, 0x7F: each beat has m_last=1, one fifo_rd per beat.
